cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling fill engine between the cache arrays and the byte-addressable, 16-bit-wide main memory.
- On a cache miss it fetches the whole block from memory as a stream of word reads, one request per cycle.
- Each returned word is written into the data array as it arrives.
- After the last word it writes the tag array once and releases the pipeline stall.
- Sits directly upstream of main memory: it is the only read requester during a fill and drives the memory's address and enable.

Parameters:
ADDR_WIDTH, 16, byte-address width of memory and cache.
BLOCK_WORDS, 8, 16-bit words per cache block. Power of two, at least 2. Block size in bytes is 2*BLOCK_WORDS.

Ports:
clk  input  1  system clock; rising edge.
rst  input  1  reset; asynchronous, active-high.
miss_detected  input  1  cache reports a miss this cycle.
miss_address  input  ADDR_WIDTH  byte address that missed; bit 0 is ignored.
fsm_busy  output  1  stall request to the pipeline.
mem_enable  output  1  memory read request.
mem_wr  output  1  memory write strobe; tied 0.
mem_addr  output  ADDR_WIDTH  memory byte address; bit 0 always 0.
memory_data_valid  input  1  memory returns one word this cycle.
memory_data  input  16  returned word.
write_data_array  output  1  data-array write strobe.
data_array_addr  output  ADDR_WIDTH  byte address of the word being written.
data_array_wdata  output  16  equals memory_data.
write_tag_array  output  1  one-cycle tag-array write strobe.
tag_array_addr  output  ADDR_WIDTH  block base address for the tag write.

Behaviour:
- States: IDLE, FILL.
- Reset:
  - State returns to IDLE asynchronously.
  - base, iss_cnt and rcv_cnt clear to 0.
  - While in reset, every output is 0.
- Address arithmetic:
  - OFS = log2(2*BLOCK_WORDS).
  - base = miss_address with bits [OFS-1:0] cleared, latched on IDLE->FILL.
  - Word address = base + (idx << 1), computed modulo 2^ADDR_WIDTH.
- IDLE:
  - All strobes are 0.
  - fsm_busy = miss_detected (combinational), so the stall begins in the miss cycle.
  - On miss_detected=1: latch base, clear both counters, go to FILL next cycle.
  - memory_data_valid is ignored.
- FILL:
  - fsm_busy = 1.
  - Issue side: mem_enable = (iss_cnt < BLOCK_WORDS) and mem_addr = base + (iss_cnt << 1). iss_cnt increments each cycle while issuing, one request per cycle, with no dependence on returns.
  - Receive side: on memory_data_valid with rcv_cnt < iss_cnt:
    - write_data_array = 1.
    - data_array_addr = base + (rcv_cnt << 1).
    - data_array_wdata = memory_data.
    - rcv_cnt increments.
  - A valid arriving when rcv_cnt >= iss_cnt is spurious: it is ignored and nothing is written.
  - In the cycle where the accepted word has rcv_cnt == BLOCK_WORDS-1:
    - write_tag_array = 1 and tag_array_addr = base.
    - Next state is IDLE, so fsm_busy is 0 in the following cycle unless a new miss arrives.
  - miss_detected is ignored during FILL; the cache re-presents the miss after the fill.
- Issue and return may overlap; an issue and a receive in the same cycle are both handled.
- Memory latency is not a parameter; completion is driven only by memory_data_valid.
- Reset asserted mid-fill: the fill is abandoned and write_tag_array is never asserted. A partially written block stays tag-invalid.
- mem_addr and tag_array_addr read 0 whenever their strobes are 0.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - Word index idx = (start + cnt) mod BLOCK_WORDS, where start = miss_address[OFS-1:1] latched with base.
  - The first request and the first data-array write target the missed word, then wrap within the block.
  - The tag write still uses base.
- Undefined: start = 0, giving sequential order as described above.

Decomposition:
- Package cache_pkg holds:
  - BLOCK_WORDS default.
  - OFS and word-index width constants.
  - fill_state_t enum {IDLE, FILL}.
  - Helper function word_addr(base, idx).
- Sub-module: fill_counter, a log2(BLOCK_WORDS)+1-bit up-counter with clear/increment and async reset. It is instantiated twice, for issue and receive.

Test Plan:
1. Miss at 0x1236 in cycle 0, memory latency 4 → mem_enable high cycles 1-8 with addresses 0x1230, 0x1232, ... 0x123E. Data writes in cycles 5-12. write_tag_array=1 with tag_array_addr=0x1230 only in cycle 12. fsm_busy=1 in cycles 0-12 and 0 in cycle 13.
2. Memory returns words with 1-cycle gaps (valid every other cycle) → 8 data writes in order. Tag write coincides with the 8th valid. No extra issues after 8.
3. Spurious memory_data_valid while IDLE, and a second miss_detected mid-FILL at 0x4000 → no writes from the spurious valid. The fill of 0x1230 completes unchanged and base stays 0x1230.
4. rst asserted in cycle 6 of scenario 1 → all outputs 0 immediately without waiting for a clock edge. No tag write. The next miss at 0x0000 fills 0x0000-0x000E cleanly.
5. Miss at 0xFFFE → base 0xFFF0, last address 0xFFFE, no overflow past the top of memory.
6. With CRITICAL_WORD_FIRST_EN, miss at 0x123A → issue order 0x123A, 0x123C, 0x123E, 0x1230, ..., 0x1238. Tag write uses 0x1230.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, fill FSM state type and block word-address helper.
package cache_pkg;
    localparam int BLOCK_WORDS_DEF = 8;
    localparam int IDX_W = $clog2(BLOCK_WORDS_DEF);
    localparam int OFS = IDX_W + 1;
    localparam int CNT_W = IDX_W + 1;
    typedef enum logic {IDLE, FILL} fill_state_t;
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 1);
    endfunction
endpackage

// File: rtl/fill_counter.sv
// fill_counter: up-counter with synchronous clear (priority) and increment.
module fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d, cnt_q;
    always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: cache miss block fill engine; define CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] data_array_addr,
    output logic [15:0]           data_array_wdata,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] tag_array_addr
);
    localparam int IW = $clog2(BLOCK_WORDS);
    localparam int OW = IW + 1;
    localparam int CW = IW + 1;
    fill_state_t state_d, state_q;
    logic [ADDR_WIDTH-1:0] base_d, base_q, iss_addr, rcv_addr;
    logic [IW-1:0] start_d, start_q, iss_idx, rcv_idx;
    logic [CW-1:0] iss_cnt, rcv_cnt;
    logic clr, iss_inc, rcv_inc;
    fill_counter #(.W(CW)) u_iss (.clk(clk), .rst(rst), .clr(clr), .inc(iss_inc), .cnt(iss_cnt));
    fill_counter #(.W(CW)) u_rcv (.clk(clk), .rst(rst), .clr(clr), .inc(rcv_inc), .cnt(rcv_cnt));
    // Word indices wrap inside the block, so the critical-word rotation never leaves it
    assign iss_idx = start_q + iss_cnt[IW-1:0];
    assign rcv_idx = start_q + rcv_cnt[IW-1:0];
    assign iss_addr = ADDR_WIDTH'(word_addr(32'(base_q), 32'(iss_idx)));
    assign rcv_addr = ADDR_WIDTH'(word_addr(32'(base_q), 32'(rcv_idx)));
    assign mem_wr = 1'b0;
    assign data_array_wdata = rst ? '0 : memory_data;
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        start_d          = start_q;
        clr              = 1'b0;
        iss_inc          = 1'b0;
        rcv_inc          = 1'b0;
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        mem_addr         = '0;
        write_data_array = 1'b0;
        data_array_addr  = '0;
        write_tag_array  = 1'b0;
        tag_array_addr   = '0;
        if (state_q == IDLE) begin
            fsm_busy = miss_detected && !rst;
            if (miss_detected) begin
                state_d = FILL;
                base_d  = miss_address & ~ADDR_WIDTH'((1 << OW) - 1);
`ifdef CRITICAL_WORD_FIRST_EN
                start_d = miss_address[OW-1:1];
`else
                start_d = '0;
`endif
                clr     = 1'b1;
            end
        end else begin
            fsm_busy         = 1'b1;
            iss_inc          = iss_cnt < CW'(BLOCK_WORDS);
            mem_enable       = iss_inc;
            mem_addr         = iss_inc ? iss_addr : '0;
            rcv_inc          = memory_data_valid && (rcv_cnt < iss_cnt);
            write_data_array = rcv_inc;
            data_array_addr  = rcv_inc ? rcv_addr : '0;
            write_tag_array  = rcv_inc && (rcv_cnt == CW'(BLOCK_WORDS - 1));
            tag_array_addr   = write_tag_array ? base_q : '0;
            state_d          = write_tag_array ? IDLE : FILL;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            start_q <= start_d;
        end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized scoreboard bench with a latency-modelling memory for cache_fill_fsm.
module tb_cache_fill_fsm;
    logic clk = 1'b0, rst = 1'b1, miss_detected = 1'b0, memory_data_valid = 1'b0;
    logic [15:0] miss_address = '0, memory_data = '0;
    logic fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array;
    logic [15:0] mem_addr, data_array_addr, data_array_wdata, tag_array_addr;

    cache_fill_fsm dut (
        .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
        .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .memory_data_valid(memory_data_valid), .memory_data(memory_data),
        .write_data_array(write_data_array), .data_array_addr(data_array_addr),
        .data_array_wdata(data_array_wdata), .write_tag_array(write_tag_array),
        .tag_array_addr(tag_array_addr)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [15:0] addr; } req_t;
    req_t rq[$];
    logic [15:0] iq[$], tq[$];
    logic [31:0] wq[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int lat = 4, gap_pct = 0, spur_pct = 0, rcvd = 0, issued = 0;
    bit alt = 0, last_vld = 0, fill_active = 0, start_next = 0, end_next = 0;
    bit miss_req = 0, extra_miss = 0, mon_on = 0, exp_busy = 0, exp_en = 0;
    logic [15:0] miss_v = '0, salt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 0);
        chk({tag, "_mem_enable"}, 32'(mem_enable), 0);
        chk({tag, "_mem_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wr_data_array"}, 32'(write_data_array), 0);
        chk({tag, "_data_array_addr"}, 32'(data_array_addr), 0);
        chk({tag, "_data_array_wdata"}, 32'(data_array_wdata), 0);
        chk({tag, "_wr_tag_array"}, 32'(write_tag_array), 0);
        chk({tag, "_tag_array_addr"}, 32'(tag_array_addr), 0);
    endtask

    // Reference: block base, word order (sequential or rotated from the missed word), returned data.
    task automatic push_exp(input logic [15:0] a);
        logic [15:0] b, w;
        int s;
        b = a & 16'hFFF0;
`ifdef CRITICAL_WORD_FIRST_EN
        s = int'((a >> 1) & 16'h7);
`else
        s = 0;
`endif
        salt = 16'($urandom);
        for (int k = 0; k < 8; k++) begin
            w = b + 16'(2 * ((s + k) % 8));
            iq.push_back(w);
            wq.push_back({w, w ^ salt});
        end
        tq.push_back(b);
    endtask

    task automatic step();
        @(negedge clk);
        if (mem_enable) rq.push_back('{cyc + lat, mem_addr});
        @(posedge clk);
        #1;
        cyc++;
        if (end_next) begin fill_active = 0; end_next = 0; end
        if (start_next) begin fill_active = 1; issued = 0; start_next = 0; end
        exp_en = fill_active && issued < 8;
        if (exp_en) issued++;
        miss_detected = 1'b0;
        if (miss_req && !fill_active) begin
            miss_detected = 1'b1;
            miss_address = miss_v;
            push_exp(miss_v);
            start_next = 1;
            miss_req = 0;
            rcvd = 0;
        end else if (extra_miss && fill_active && issued > 3) begin
            miss_detected = 1'b1;
            miss_address = 16'h4000;
            extra_miss = 0;
        end
        exp_busy = fill_active || miss_detected;
        memory_data_valid = 1'b0;
        memory_data = 16'($urandom);
        if (rq.size() > 0 && rq[0].due <= cyc && (alt ? !last_vld : ($urandom_range(99) >= 32'(gap_pct)))) begin
            memory_data_valid = 1'b1;
            memory_data = rq[0].addr ^ salt;
            void'(rq.pop_front());
            rcvd++;
            if (rcvd == 8) end_next = 1;
        end else if (rq.size() == 0 && $urandom_range(99) < 32'(spur_pct)) begin
            memory_data_valid = 1'b1;
        end
        last_vld = memory_data_valid;
    endtask

    task automatic run_fill(input logic [15:0] a, input int l, input bit al, input int gp, input int sp, input bit xm);
        lat = l; alt = al; gap_pct = gp; spur_pct = sp;
        miss_v = a; miss_req = 1; extra_miss = xm;
        for (int i = 0; i < 300 && (miss_req || start_next || fill_active); i++) step();
        chk("fill_completes", 32'(fill_active || miss_req || start_next), 0);
        repeat (2) step();
    endtask

    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (mon_on) begin
            chk("busy", 32'(fsm_busy), 32'(exp_busy));
            chk("mem_enable", 32'(mem_enable), 32'(exp_en));
            chk("mem_wr", 32'(mem_wr), 0);
            if (mem_enable && iq.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(iq.pop_front()));
            else if (!mem_enable) chk("mem_addr_idle", 32'(mem_addr), 0);
            if (write_data_array) begin
                chk("wr_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(data_array_addr), 32'(e[31:16]));
                    chk("wr_data", 32'(data_array_wdata), 32'(e[15:0]));
                end
            end
            if (write_tag_array) begin
                chk("tag_expected", 32'(tq.size() > 0), 1);
                if (tq.size() > 0) chk("tag_addr", 32'(tag_array_addr), 32'(tq.pop_front()));
                chk("tag_with_word", 32'(write_data_array), 1);
                chk("tag_after_all_words", 32'(wq.size()), 0);
            end else chk("tag_addr_idle", 32'(tag_array_addr), 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        miss_detected = 1'b1;
        miss_address = 16'h1236;
        memory_data_valid = 1'b1;
        memory_data = 16'h5A5A;
        #3;
        check_zero("rst_init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
        mon_on = 1;
        repeat (2) step();
        run_fill(16'h1236, 4, 0, 0, 0, 0);
        run_fill(16'($urandom), 1, 1, 0, 0, 0);
        spur_pct = 100;
        repeat (3) step();
        run_fill(16'h1230, 2, 0, 30, 60, 1);
        // Abandon a fill by reset partway through, then refill block 0
        lat = 4; alt = 0; gap_pct = 0; spur_pct = 0;
        miss_v = 16'h1236; miss_req = 1;
        repeat (7) step();
        #2;
        mon_on = 0;
        rst = 1'b1;
        miss_detected = 1'b1;
        miss_address = 16'h1234;
        memory_data_valid = 1'b1;
        memory_data = 16'hBEEF;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst = 1'b0;
        miss_detected = 1'b0;
        memory_data_valid = 1'b0;
        rq.delete(); iq.delete(); wq.delete(); tq.delete();
        fill_active = 0; start_next = 0; end_next = 0; miss_req = 0; extra_miss = 0;
        exp_busy = 0; exp_en = 0; last_vld = 0;
        mon_on = 1;
        run_fill(16'h0000, 3, 0, 0, 0, 0);
        run_fill(16'hFFFE, 3, 0, 20, 20, 0);
        run_fill(16'h123A, 2, 0, 0, 0, 0);
        for (int n = 0; n < 25; n++)
            run_fill(16'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 50)), int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
        chk("issues_outstanding", 32'(iq.size()), 0);
        chk("writes_outstanding", 32'(wq.size()), 0);
        chk("tags_outstanding", 32'(tq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
